probe_trace_buffer: RTL and testbench

- Capture stage downstream of the DUT in the svsim harness.
- Watches one probe signal and records every value change, tagged with a cycle timestamp, into an on-chip FIFO.
- The testbench drains the FIFO through a valid/ready port via DPI getters, so forced or probed values can be checked after the fact without per-cycle DPI polling.

---
 rtl/probe_trace_buffer.sv | 137 +++++++++++++
 tb/tb_probe_trace_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/probe_trace_buffer.sv
// Change-capture trace buffer: records {probe_value, timestamp} on every probe change into a FIFO.
// Optional PROBE_TRACE_DROP_COUNT_EN adds a saturating drop_count output.
module probe_trace_buffer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         probe_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_value,
  output logic [TS_WIDTH-1:0]      out_timestamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef PROBE_TRACE_DROP_COUNT_EN
  ,
  output logic [TS_WIDTH-1:0]      drop_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = WIDTH + TS_WIDTH;

  logic [EW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [TS_WIDTH-1:0] r_ts;
  logic [WIDTH-1:0]    r_last_value;
  logic                r_have_last;

  logic                w_capture;
  logic                w_pop;
  logic                w_full;
  logic                w_push;
  logic                w_drop;
  logic [EW-1:0]       w_head;

  always_comb begin
    w_capture = enable & (~r_have_last | (probe_value != r_last_value));
    w_pop     = (r_count != '0) & out_ready;
    w_full    = (r_count == CW'(DEPTH));
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    w_push    = w_capture & (~w_full | w_pop);
    w_drop    = w_capture & w_full & ~w_pop;
    w_head    = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (!reset && !clear && w_push) begin
      r_mem[r_wr_ptr] <= {probe_value, r_ts};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_ts         <= '0;
      r_last_value <= '0;
      r_have_last  <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ts        <= '0;
      r_have_last <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_capture) begin
        r_last_value <= probe_value;
      end
      // With enable high and no capture, have_last is already set.
      r_have_last <= enable;
    end
  end

`ifdef PROBE_TRACE_DROP_COUNT_EN
  logic [TS_WIDTH-1:0] r_drop_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drop_count <= '0;
    end else if (clear) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != '1)) begin
      r_drop_count <= r_drop_count + TS_WIDTH'(1);
    end
  end

  assign drop_count = r_drop_count;
  assign overflow   = (r_drop_count != '0);
`else
  logic r_overflow;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
`endif

  always_comb begin
    out_valid     = (r_count != '0);
    out_value     = '0;
    out_timestamp = '0;
    if (out_valid) begin
      out_value     = w_head[EW-1:TS_WIDTH];
      out_timestamp = w_head[TS_WIDTH-1:0];
    end
    count = r_count;
  end

endmodule

// File: tb/tb_probe_trace_buffer.sv
// Directed bench for probe_trace_buffer with a queue scoreboard of expected trace entries.
module tb_probe_trace_buffer;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned TW = 32;
  localparam int unsigned EW = W + TW;

  logic                 clock;
  logic                 reset;
  logic                 enable;
  logic                 clear;
  logic [W-1:0]         probe_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_value;
  logic [TW-1:0]        out_timestamp;
  logic [$clog2(D):0]   count;
  logic                 overflow;
`ifdef PROBE_TRACE_DROP_COUNT_EN
  logic [TW-1:0]        drop_count;
`endif

  probe_trace_buffer #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(TW)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .clear         (clear),
    .probe_value   (probe_value),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_value     (out_value),
    .out_timestamp (out_timestamp),
    .count         (count),
    .overflow      (overflow)
`ifdef PROBE_TRACE_DROP_COUNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned  n_vec;
  int unsigned  n_fail;

  logic [EW-1:0] q[$];
  logic [TW-1:0] m_ts;
  logic [W-1:0]  m_last;
  logic          m_have;
  logic          m_ovf;
  int unsigned   m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts   = '0;
    m_last = '0;
    m_have = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_state();
    logic [EW-1:0] h;
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef PROBE_TRACE_DROP_COUNT_EN
    chk("drop_count", 64'(drop_count), 64'(m_drop));
`endif
    if (q.size() != 0) begin
      h = q[0];
      chk("head_value", 64'(out_value), 64'(h[EW-1:TW]));
      chk("head_ts", 64'(out_timestamp), 64'(h[TW-1:0]));
    end else begin
      chk("idle_value", 64'(out_value), 64'd0);
      chk("idle_ts", 64'(out_timestamp), 64'd0);
    end
  endtask

  // Called at a negedge: drives inputs, predicts the next posedge, then checks at the following negedge.
  task automatic step(input logic en, input logic [W-1:0] val, input logic rdy, input logic clr);
    logic [EW-1:0] e;
    logic          pop;
    logic          cap;
    enable      = en;
    probe_value = val;
    out_ready   = rdy;
    clear       = clr;
    #1;
    pop = rdy && (q.size() != 0);
    cap = en && (!m_have || (val != m_last));
    if (clr) begin
      q.delete();
      m_ts   = '0;
      m_have = 1'b0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      if (pop) begin
        e = q.pop_front();
        chk("pop_value", 64'(out_value), 64'(e[EW-1:TW]));
        chk("pop_ts", 64'(out_timestamp), 64'(e[TW-1:0]));
      end
      if (cap) begin
        if (q.size() < D) begin
          q.push_back({val, m_ts});
        end else begin
          m_ovf  = 1'b1;
          m_drop = m_drop + 1;
        end
        m_last = val;
      end
      m_have = en;
      m_ts   = m_ts + 1;
    end
    @(negedge clock);
    check_state();
  endtask

  initial begin
    n_vec       = 0;
    n_fail      = 0;
    reset       = 1'b1;
    enable      = 1'b0;
    clear       = 1'b0;
    probe_value = '0;
    out_ready   = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_state();

    // Change detect: 0x05 at edges 0-2, 0x07 at edge 3.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h05, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    chk("cd_count2", 64'(count), 64'd2);
    chk("cd_head_ts0", 64'(out_timestamp), 64'd0);

    // Enable gating: edges 4-6 disabled, edge 7 re-enabled with the same value.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h07, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    chk("gate_count3", 64'(count), 64'd3);

    // Drain the three entries through the scoreboard.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h07, 1'b1, 1'b0);

    // Overflow: 18 captures with no consumer.
    for (int i = 0; i < 18; i++) step(1'b1, (i % 2 == 0) ? 8'hA5 : 8'h5A, 1'b0, 1'b0);
    chk("ovf_count16", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
`ifdef PROBE_TRACE_DROP_COUNT_EN
    chk("ovf_drop2", 64'(drop_count), 64'd2);
`endif

    // Full with simultaneous push and pop.
    step(1'b1, 8'hC3, 1'b1, 1'b0);
    chk("fullpp_count16", 64'(count), 64'd16);
    chk("fullpp_ovf", 64'(overflow), 64'd1);

    // Drain to five entries, then clear on an edge with a capture and a pop.
    for (int i = 0; i < 11; i++) step(1'b0, 8'hC3, 1'b1, 1'b0);
    chk("pre_clear_count5", 64'(count), 64'd5);
    step(1'b1, 8'h3C, 1'b1, 1'b1);
    chk("clr_count0", 64'(count), 64'd0);
    chk("clr_ovf0", 64'(overflow), 64'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("clr_rec_ts0", 64'(out_timestamp), 64'd0);
    chk("clr_rec_val", 64'(out_value), 64'h3C);

    // Build to four entries, pop one, then reset between edges.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 8'h33, 1'b1, 1'b0);
    chk("mid_count3", 64'(count), 64'd3);
    out_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_value", 64'(out_value), 64'd0);
    chk("arst_ts", 64'(out_timestamp), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("post_rst_ts0", 64'(out_timestamp), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
